// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// One operation at a time. A request is taken when start=1 while ready=1;
// operands are latched and a radix-2 shift-add multiply or restoring divide
// runs on operand magnitudes for 32 BUSY cycles. Sign correction is applied
// on the final iteration. Divide-by-zero and signed overflow skip the loop
// and go straight to DONE. The result is held in DONE until the consumer
// handshakes with result_ready.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request valid (taken when ready=1)
//   op[2:0]      RV32M funct3 (MUL..REMU)
//   src_a        rs1: multiplicand / dividend
//   src_b        rs2: multiplier / divisor
//   ready        high in IDLE
//   busy         high in BUSY and DONE
//   result_valid high in DONE
//   result_ready consumer accepts result
//   result       registered result
//   zero         result == 0 (meaningful while result_valid=1)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            ready,
    output logic            busy,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic [2:0]        op_q;
    logic              neg_q;      // negate final result (quotient/product/remainder)
    logic [XLEN-1:0]   dsr_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;      // {hi, lo} working register
    logic [XLEN-1:0]   res_q;
    logic              zero_q;

    // ------------------------------------------------------------------
    // Accept-time decode: operand signedness, magnitudes, fast paths.
    // ------------------------------------------------------------------
    logic            is_div, a_sgn, b_sgn, neg_new;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    always_comb begin
        is_div   = op[2];
        a_sgn    = src_a[XLEN-1] &&
                   (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        b_sgn    = src_b[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        mag_a    = a_sgn ? (~src_a + 1'b1) : src_a;
        mag_b    = b_sgn ? (~src_b + 1'b1) : src_b;
        // Remainder follows the dividend; quotient/product follow the sign xor.
        neg_new  = (is_div && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero = is_div && (src_b == '0);
        // Only the signed forms (op[0]=0) can overflow.
        div_ovf  = is_div && !op[0] && (src_a == INT_MIN) && (src_b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_res = op[1] ? src_a : '1;
        else
            fast_res = op[1] ? '0 : INT_MIN;
    end

    // ------------------------------------------------------------------
    // One radix-2 step.
    //   mul: acc = {partial_hi, multiplier}; add multiplicand when the
    //        current multiplier LSB is set, then shift right.
    //   div: acc = {partial_rem, dividend}; shift left, trial-subtract the
    //        divisor, keep the difference and shift in 1 if non-negative.
    // After 32 steps: mul -> acc is the 64-bit product;
    //                 div -> acc = {remainder, quotient}.
    // ------------------------------------------------------------------
    logic [XLEN:0]     add_sum, trial;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
        trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dsr_q};
        if (op_q[2]) begin
            if (trial[XLEN])
                acc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection on the last step's output.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

    always_comb begin
        prod    = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        quo     = neg_q ? (~acc_nxt[XLEN-1:0] + 1'b1) : acc_nxt[XLEN-1:0];
        rem     = neg_q ? (~acc_nxt[2*XLEN-1:XLEN] + 1'b1) : acc_nxt[2*XLEN-1:XLEN];
        fin_res = '0;
        case (op_q)
            OP_MUL:                       fin_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res = quo;
            OP_REM, OP_REMU:              fin_res = rem;
            default:                      fin_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            dsr_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        neg_q <= neg_new;
                        cnt   <= '0;
                        if (fast) begin
                            res_q  <= fast_res;
                            zero_q <= (fast_res == '0);
                            state  <= S_DONE;
                        end else begin
                            dsr_q <= is_div ? mag_b : mag_a;
                            acc_q <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_nxt;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        res_q  <= fin_res;
                        zero_q <= (fin_res == '0);
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready        = (state == S_IDLE);
    assign busy         = (state == S_BUSY) || (state == S_DONE);
    assign result_valid = (state == S_DONE);
    assign result       = res_q;
    assign zero         = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed RV32M cases plus randomized operations
// against an arithmetic reference model. Latency is counted in edges with the
// accept edge as edge 1 (normal path 33, fast path 1).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        ready, busy, result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic        zero;

    muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Architectural RV32M result from plain integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * ub;                 return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, " ready"}, ready, 1'b1);
    endtask

    // Issue one operation, check latency/result/zero, optionally apply
    // backpressure and a stray start during BUSY, then handshake.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input bit poke);
        logic [31:0] exp;
        int          lat, want;
        bit          bsy_ok, held_ok;
        exp  = ref_res(f, a, b);
        want = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        wait_ready(tag);
        start = 1'b1; op = f; src_a = a; src_b = b;
        @(posedge clk); #1;
        // Scramble inputs: the operation in flight must not see them.
        start = 1'b0; op = 3'($urandom_range(0, 7)); src_a = $urandom; src_b = $urandom;
        lat = 1; bsy_ok = 1'b1;
        while (!result_valid && lat < 40) begin
            if (!busy) bsy_ok = 1'b0;
            start = poke && (lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(want));
        if (want == 33) chk({tag, " busy in flight"}, bsy_ok, 1'b1);
        chk({tag, " busy in done"}, busy, 1'b1);
        chk({tag, " result"}, result, exp);
        chk({tag, " zero"}, zero, exp == 0);
        held_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!result_valid || result !== exp || zero !== (exp == 0)) held_ok = 1'b0;
        end
        if (hold > 0) chk({tag, " held under backpressure"}, held_ok, 1'b1);
        // A start presented on the handshake edge must not be taken.
        result_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0; start = 1'b0;
        chk({tag, " ready after handshake"}, {ready, result_valid}, 2'b10);
        chk({tag, " result retained"}, result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          n;
        bit          no_valid;

        // Reset with start asserted: start must be ignored.
        rst_n = 1'b0; start = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {ready, busy, result_valid, zero}, 4'b1001);
        chk("reset result", result, 32'h0);
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", {ready, busy}, 2'b10);

        // Directed cases.
        run_op("MUL 7*-3",          3'd0, 32'd7,        32'hFFFF_FFFD, 5, 1'b1);
        run_op("MULHU -1*-1",       3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("MULH -1*-1",        3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("MULHSU -1*-1",      3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("DIV -7/2",          3'd4, 32'hFFFF_FFF9, 32'd2,         0, 1'b1);
        run_op("REM -7/2",          3'd6, 32'hFFFF_FFF9, 32'd2,         0, 1'b0);
        run_op("DIVU 100/7",        3'd5, 32'd100,      32'd7,          0, 1'b0);
        run_op("REMU 100/7",        3'd7, 32'd100,      32'd7,          0, 1'b0);
        run_op("DIVU 100/0",        3'd5, 32'd100,      32'd0,          3, 1'b0);
        run_op("REMU 100/0",        3'd7, 32'd100,      32'd0,          0, 1'b0);
        run_op("DIV ovf",           3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("REM ovf",           3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("MUL 0*x no fast",   3'd0, 32'd0,        32'h1234_5678, 0, 1'b0);
        run_op("DIVU 100/7 again",  3'd5, 32'd100,      32'd7,          0, 1'b0);

        // Reset in the middle of BUSY.
        wait_ready("abort");
        start = 1'b1; op = 3'd0; src_a = 32'h1234_5678; src_b = 32'h0000_9ABC;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort state", {ready, busy, result_valid, zero}, 4'b1001);
        chk("abort result", result, 32'h0);
        no_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_valid) no_valid = 1'b0;
        end
        chk("abort no valid pulse", no_valid, 1'b1);
        run_op("MUL 3*4 after abort", 3'd0, 32'd3, 32'd4, 0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            n = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d op%0d %h %h", i, f, a, b), f, a, b, n, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request valid; a request is accepted when start=1 and ready=1 at a rising edge.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 src_a  input  32  rs1 operand (multiplicand/dividend).
REQ-007 src_b  input  32  rs2 operand (multiplier/divisor).
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high in BUSY and DONE.
REQ-010 result_valid  output  1  high only in DONE.
REQ-011 result_ready  input  1  consumer accepts result when result_valid=1 and result_ready=1 at a rising edge.
REQ-012 result  output  32  registered result.
REQ-013 zero  output  1  result==0, valid while result_valid=1.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; one-hot or binary encoding.
REQ-015 On accept, latch op, src_a and src_b; later input changes do not affect the operation in flight.
REQ-016 start while ready=0 is ignored, with no queuing.
REQ-017 Transitions: IDLE->BUSY on accept (normal path); IDLE->DONE on accept (fast path, REQ-021/022); BUSY->DONE when the iteration counter reaches 31; DONE->IDLE on result handshake; all other cycles hold state.
REQ-018 Normal path: 5-bit counter cleared on accept; one radix-2 iteration per BUSY cycle; exactly 32 BUSY cycles. result_valid rises on the 33rd rising edge after the accept edge.
REQ-019 Multiply: iterative shift-add on magnitudes with sign correction, 64-bit product. MUL returns bits [31:0]. MULH treats both operands as signed, MULHSU src_a signed and src_b unsigned, MULHU both unsigned; these three return bits [63:32].
REQ-020 Divide: restoring division on magnitudes. Quotient is negated when operand signs differ (DIV). Remainder takes the dividend's sign (REM). Quotient truncates toward zero.
REQ-021 Divide-by-zero (src_b=0) is a fast path to DONE on the next edge: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src_a.
REQ-022 Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF) is a fast path: DIV gives 0x80000000, REM gives 0.
REQ-023 The multiply path has no fast path, including zero operands.
REQ-024 In DONE, result and zero are held stable until the handshake, for any length of result_ready=0 backpressure.
REQ-025 DONE->IDLE on handshake: ready=1 in the following cycle; a new start is accepted no earlier than the edge after the handshake edge.
REQ-026 result and zero retain their last value outside DONE; consumers sample them only when result_valid=1.
REQ-027 No combinational path from inputs to outputs.

Reset
REQ-028 rst_n=0 at a rising edge forces IDLE and clears counter and result: ready=1, busy=0, result_valid=0, result=0x00000000, zero=1.
REQ-029 Reset mid-operation (BUSY or DONE) aborts the operation with no result_valid pulse. The first start after rst_n returns high is accepted normally.
REQ-030 While rst_n=0, start is ignored.

Verification
REQ-031 MUL src_a=7, src_b=0xFFFFFFFD -> result=0xFFFFFFEB; result_valid on the 33rd edge after accept; busy high throughout.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000, zero=1. MULHSU same operands -> 0xFFFFFFFF.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each with result_valid one edge after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM same operands -> 0, each one edge after accept.
REQ-035 result_ready held 0 for 5 cycles in DONE -> result and result_valid unchanged. A start pulse during BUSY is ignored, and the result matches the originally latched operands.
REQ-036 rst_n=0 for one edge at BUSY iteration 10 -> next cycle ready=1, result_valid=0, result=0. A following MUL 3x4 returns 12 with full 33-edge latency.
